// File: rtl/biquad8_pkg.sv
// Shared constants for the biquad8 pole IIR and its coefficient loader.
// The loader's state encoding lives here so other code can refer to states by name.
package biquad8_pkg;

    localparam int BQ_NCHAIN     = 4;
    localparam int BQ_COEFF_BITS = 18;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SHIFT  = ST_SHIFT,
        S_UPDATE = ST_UPDATE,
        S_DONE   = ST_DONE
    } ldr_state_t;

endpackage

// File: rtl/biquad8_pole_coeff_loader.sv
// Coefficient sequencer for the biquad8 pole DSP chain: shadow bank, commit snapshot,
// serial B1 shift (highest slot first) and a single B2 update strobe.
//
// state  | meaning
// IDLE   | waiting for a commit or a pending load
// SHIFT  | one staged slot per cycle onto the B1 cascade
// UPDATE | one-cycle B2 load strobe
// DONE   | one-cycle completion pulse
module biquad8_pole_coeff_loader
    import biquad8_pkg::*;
#(
    parameter int NCHAIN     = BQ_NCHAIN,
    parameter int COEFF_BITS = BQ_COEFF_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(NCHAIN)-1:0] cfg_addr_i,
    input  logic [COEFF_BITS-1:0]     cfg_dat_i,
    input  logic                      cfg_wr_i,
    input  logic                      cfg_commit_i,
    output logic [COEFF_BITS-1:0]     coeff_dat_o,
    output logic                      coeff_wr_o,
    output logic                      coeff_update_o,
    output logic                      busy_o,
    output logic                      done_o
);
    localparam int            AW      = $clog2(NCHAIN);
    localparam logic [AW-1:0] CNT_TOP = AW'(NCHAIN - 1);
    localparam logic [AW:0]   N_SLOTS = (AW + 1)'(NCHAIN);

    ldr_state_t            r_state;
    logic [AW-1:0]         r_cnt;
    logic                  r_pend;
    logic [COEFF_BITS-1:0] r_shadow [NCHAIN];
    logic [COEFF_BITS-1:0] r_stage  [NCHAIN];

    ldr_state_t            w_state_nxt;
    logic [AW-1:0]         w_cnt_nxt;
    logic                  w_pend_nxt;
    logic                  w_snap;
    logic                  w_wr_nxt;
    logic [COEFF_BITS-1:0] w_dat_nxt;
    logic                  w_upd_nxt;
    logic                  w_done_nxt;
    logic                  w_busy_nxt;
    logic                  w_addr_ok;

    assign w_addr_ok = ({1'b0, cfg_addr_i} < N_SLOTS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_snap      = 1'b0;
        w_wr_nxt    = 1'b0;
        w_dat_nxt   = '0;
        w_upd_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cfg_commit_i || r_pend) begin
                    w_snap      = 1'b1;
                    w_pend_nxt  = 1'b0;
                    w_cnt_nxt   = CNT_TOP;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_wr_nxt   = 1'b1;
                w_dat_nxt  = r_stage[r_cnt];
                w_cnt_nxt  = r_cnt - 1'b1;
                w_pend_nxt = r_pend | cfg_commit_i;
                if (r_cnt == '0) begin
                    w_state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_upd_nxt   = 1'b1;
                w_pend_nxt  = r_pend | cfg_commit_i;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_pend_nxt  = r_pend | cfg_commit_i;
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_UPDATE);
    end

    // Non-blocking snapshot reads the shadow before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCHAIN; k++) begin
                r_shadow[k] <= '0;
                r_stage[k]  <= '0;
            end
        end else begin
            if (cfg_wr_i && w_addr_ok) begin
                r_shadow[cfg_addr_i] <= cfg_dat_i;
            end
            if (w_snap) begin
                r_stage <= r_shadow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coeff_dat_o    <= '0;
            coeff_wr_o     <= 1'b0;
            coeff_update_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            coeff_dat_o    <= w_dat_nxt;
            coeff_wr_o     <= w_wr_nxt;
            coeff_update_o <= w_upd_nxt;
            busy_o         <= w_busy_nxt;
            done_o         <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_biquad8_pole_coeff_loader.sv
// Directed bench for the pole coefficient loader: NCHAIN=4 instance with a B1/B2
// chain model, plus an NCHAIN=3 instance for out-of-range shadow writes.
module tb_biquad8_pole_coeff_loader;
    import biquad8_pkg::*;

    localparam int CB = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cfg_addr_i;
    logic [CB-1:0] cfg_dat_i;
    logic          cfg_wr_i;
    logic          cfg_commit_i;
    logic [CB-1:0] coeff_dat_o;
    logic          coeff_wr_o, coeff_update_o, busy_o, done_o;

    logic [1:0]    cfg_addr3;
    logic [CB-1:0] cfg_dat3;
    logic          cfg_wr3, cfg_commit3;
    logic [CB-1:0] coeff_dat3;
    logic          coeff_wr3, coeff_update3, busy3, done3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    biquad8_pole_coeff_loader #(.NCHAIN(4), .COEFF_BITS(CB)) u_dut (
        .clk(clk), .rst(rst),
        .cfg_addr_i(cfg_addr_i), .cfg_dat_i(cfg_dat_i),
        .cfg_wr_i(cfg_wr_i), .cfg_commit_i(cfg_commit_i),
        .coeff_dat_o(coeff_dat_o), .coeff_wr_o(coeff_wr_o),
        .coeff_update_o(coeff_update_o), .busy_o(busy_o), .done_o(done_o)
    );

    biquad8_pole_coeff_loader #(.NCHAIN(3), .COEFF_BITS(CB)) u_dut3 (
        .clk(clk), .rst(rst),
        .cfg_addr_i(cfg_addr3), .cfg_dat_i(cfg_dat3),
        .cfg_wr_i(cfg_wr3), .cfg_commit_i(cfg_commit3),
        .coeff_dat_o(coeff_dat3), .coeff_wr_o(coeff_wr3),
        .coeff_update_o(coeff_update3), .busy_o(busy3), .done_o(done3)
    );

    // Behavioural 4-deep DSP chain: B1 cascade shifts on wr, B2 loads on update, no reset.
    logic [CB-1:0] b1 [4];
    logic [CB-1:0] b2 [4];
    always @(posedge clk) begin
        if (coeff_wr_o) begin
            b1[0] <= coeff_dat_o;
            for (int k = 1; k < 4; k++) b1[k] <= b1[k-1];
        end
        if (coeff_update_o) begin
            for (int k = 0; k < 4; k++) b2[k] <= b1[k];
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(negedge clk);
        cfg_wr_i     = 1'b0;
        cfg_commit_i = 1'b0;
        cfg_wr3      = 1'b0;
        cfg_commit3  = 1'b0;
    endtask

    task automatic wr_shadow(input logic [1:0] a, input logic [CB-1:0] d);
        cfg_addr_i = a;
        cfg_dat_i  = d;
        cfg_wr_i   = 1'b1;
        step();
    endtask

    task automatic start();
        cfg_commit_i = 1'b1;
        step();
    endtask

    // Called just after the commit edge; s[k] is the expected slot k word.
    task automatic expect_seq(input string tag, input logic [3:0][CB-1:0] s);
        chk_eq({tag, "_pre_wr"}, 32'(coeff_wr_o), 32'd0);
        for (int i = 3; i >= 0; i--) begin
            step();
            chk_eq({tag, "_wr"},   32'(coeff_wr_o), 32'd1);
            chk_eq({tag, "_dat"},  32'(coeff_dat_o), 32'(s[i]));
            chk_eq({tag, "_upd"},  32'(coeff_update_o), 32'd0);
            chk_eq({tag, "_busy"}, 32'(busy_o), 32'd1);
        end
        step();
        chk_eq({tag, "_upd_pulse"}, 32'(coeff_update_o), 32'd1);
        chk_eq({tag, "_upd_wr"},    32'(coeff_wr_o), 32'd0);
        chk_eq({tag, "_upd_dat"},   32'(coeff_dat_o), 32'd0);
        chk_eq({tag, "_upd_done"},  32'(done_o), 32'd0);
        step();
        chk_eq({tag, "_done"},      32'(done_o), 32'd1);
        chk_eq({tag, "_done_upd"},  32'(coeff_update_o), 32'd0);
        chk_eq({tag, "_done_busy"}, 32'(busy_o), 32'd0);
        step();
        chk_eq({tag, "_done_end"},  32'(done_o), 32'd0);
    endtask

    initial begin
        int n_wr, n_done, first_wr2, n_upd_bad;
        rst = 1'b1;
        cfg_addr_i = '0; cfg_dat_i = '0; cfg_wr_i = 1'b0; cfg_commit_i = 1'b0;
        cfg_addr3 = '0;  cfg_dat3 = '0;  cfg_wr3 = 1'b0;  cfg_commit3 = 1'b0;
        step();
        step();
        chk_eq("rst_dat",  32'(coeff_dat_o), 32'd0);
        chk_eq("rst_wr",   32'(coeff_wr_o), 32'd0);
        chk_eq("rst_upd",  32'(coeff_update_o), 32'd0);
        chk_eq("rst_busy", 32'(busy_o), 32'd0);
        chk_eq("rst_done", 32'(done_o), 32'd0);
        rst = 1'b0;
        step();

        // Basic load
        wr_shadow(2'd0, 18'h00001);
        wr_shadow(2'd1, 18'h00002);
        wr_shadow(2'd2, 18'h00003);
        wr_shadow(2'd3, 18'h3FFFF);
        start();
        expect_seq("basic", {18'h3FFFF, 18'h00003, 18'h00002, 18'h00001});
        chk_eq("basic_b2_0", 32'(b2[0]), 32'h00001);
        chk_eq("basic_b2_1", 32'(b2[1]), 32'h00002);
        chk_eq("basic_b2_2", 32'(b2[2]), 32'h00003);
        chk_eq("basic_b2_3", 32'(b2[3]), 32'h3FFFF);

        // Snapshot isolation: shadow write during SHIFT
        start();
        cfg_addr_i = 2'd3; cfg_dat_i = 18'h12345; cfg_wr_i = 1'b1;
        expect_seq("iso_old", {18'h3FFFF, 18'h00003, 18'h00002, 18'h00001});
        start();
        expect_seq("iso_new", {18'h12345, 18'h00003, 18'h00002, 18'h00001});

        // Collapsed pending: commits at edges 0, 1, 3, 5
        start();
        n_wr = 0; n_done = 0; first_wr2 = 0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 1 || c == 3 || c == 5) cfg_commit_i = 1'b1;
            step();
            if (coeff_wr_o) n_wr++;
            if (done_o) n_done++;
            if (c == 7) chk_eq("pend_gap_wr", 32'(coeff_wr_o), 32'd0);
            if (c == 8) chk_eq("pend_2nd_dat", 32'(coeff_dat_o), 32'h12345);
            if (c == 12) chk_eq("pend_2nd_upd", 32'(coeff_update_o), 32'd1);
            if (c > 6 && coeff_wr_o && first_wr2 == 0) first_wr2 = c;
        end
        chk_eq("pend_wr_count",   32'(n_wr), 32'd8);
        chk_eq("pend_done_count", 32'(n_done), 32'd2);
        chk_eq("pend_first_wr2",  32'(first_wr2), 32'd8);

        // Same-cycle write and commit
        cfg_addr_i = 2'd0; cfg_dat_i = 18'h00AAA; cfg_wr_i = 1'b1;
        start();
        expect_seq("same_old", {18'h12345, 18'h00003, 18'h00002, 18'h00001});
        start();
        expect_seq("same_new", {18'h12345, 18'h00003, 18'h00002, 18'h00AAA});

        // Reset at the second SHIFT cycle
        start();
        step();
        chk_eq("mrst_wr1", 32'(coeff_wr_o), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_eq("mrst_dat",  32'(coeff_dat_o), 32'd0);
        chk_eq("mrst_wr",   32'(coeff_wr_o), 32'd0);
        chk_eq("mrst_upd",  32'(coeff_update_o), 32'd0);
        chk_eq("mrst_busy", 32'(busy_o), 32'd0);
        chk_eq("mrst_done", 32'(done_o), 32'd0);
        n_upd_bad = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (coeff_update_o || coeff_wr_o) n_upd_bad++;
        end
        chk_eq("mrst_quiet", 32'(n_upd_bad), 32'd0);
        chk_eq("mrst_b2_0", 32'(b2[0]), 32'h00AAA);
        chk_eq("mrst_b2_1", 32'(b2[1]), 32'h00002);
        chk_eq("mrst_b2_2", 32'(b2[2]), 32'h00003);
        chk_eq("mrst_b2_3", 32'(b2[3]), 32'h12345);
        start();
        expect_seq("mrst_zero", {18'h0, 18'h0, 18'h0, 18'h0});

        // NCHAIN=3: address 3 is out of range
        cfg_addr3 = 2'd0; cfg_dat3 = 18'h0000A; cfg_wr3 = 1'b1; step();
        cfg_addr3 = 2'd1; cfg_dat3 = 18'h0000B; cfg_wr3 = 1'b1; step();
        cfg_addr3 = 2'd2; cfg_dat3 = 18'h0000C; cfg_wr3 = 1'b1; step();
        cfg_addr3 = 2'd3; cfg_dat3 = 18'h11111; cfg_wr3 = 1'b1; step();
        cfg_commit3 = 1'b1;
        step();
        n_wr = 0;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (coeff_wr3) n_wr++;
            if (e == 1) chk_eq("n3_dat1", 32'(coeff_dat3), 32'h0000C);
            if (e == 2) chk_eq("n3_dat2", 32'(coeff_dat3), 32'h0000B);
            if (e == 3) chk_eq("n3_dat3", 32'(coeff_dat3), 32'h0000A);
            if (e == 4) chk_eq("n3_upd",  32'(coeff_update3), 32'd1);
            if (e == 5) chk_eq("n3_done", 32'(done3), 32'd1);
        end
        chk_eq("n3_wr_count", 32'(n_wr), 32'd3);
        chk_eq("n4_idle_wr",  32'(coeff_wr_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
